// File: rtl/gshare_predictor.sv
// Fetch-stage gshare direction predictor with a speculative global history
// register, a 2-bit counter PHT and a return-address stack for JALR returns.
module gshare_predictor #(
  parameter int IDX_BITS  = 6,
  parameter int GH_SIZE   = 6,
  parameter int RAS_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                fetch_valid_i,
  input  logic [31:0]         instruction_i,
  input  logic [31:0]         pc_i,
  output logic                br_pred_o,
  output logic [31:0]         new_pc_pred_o,
  output logic [IDX_BITS-1:0] pred_idx_o,
  output logic [GH_SIZE-1:0]  pred_ghr_o,
  input  logic                res_valid_i,
  input  logic                res_taken_i,
  input  logic                res_miss_i,
  input  logic [IDX_BITS-1:0] res_idx_i,
  input  logic [GH_SIZE-1:0]  res_ghr_i
);

  localparam int PHT_SIZE = 2**IDX_BITS;
  localparam int RP = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH + 1);
  localparam logic [CW-1:0] RAS_FULL = CW'(RAS_DEPTH);

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  logic [GH_SIZE-1:0] ghr;
  logic [1:0]         pht [PHT_SIZE];
  logic [31:0]        ras [RAS_DEPTH];
  logic [RP-1:0]      top;
  logic [CW-1:0]      count;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [31:0] imm_b;
  logic [31:0] imm_j;
  logic [31:0] pc_next;
  logic        is_cond;
  logic        is_jal;
  logic        is_jalr;
  logic        link_rd;
  logic        link_rs1;
  logic        is_ret;
  logic        is_swap;
  logic        is_push;
  logic        taken;

  assign opcode   = instruction_i[6:0];
  assign funct3   = instruction_i[14:12];
  assign rd       = instruction_i[11:7];
  assign rs1      = instruction_i[19:15];
  assign imm_b    = {{19{instruction_i[31]}}, instruction_i[31],
                     instruction_i[7], instruction_i[30:25],
                     instruction_i[11:8], 1'b0};
  assign imm_j    = {{11{instruction_i[31]}}, instruction_i[31],
                     instruction_i[19:12], instruction_i[20],
                     instruction_i[30:21], 1'b0};
  assign pc_next  = pc_i + 32'd4;

  assign is_cond  = (opcode == OP_BRANCH) &&
                    (funct3 != 3'b010) && (funct3 != 3'b011);
  assign is_jal   = (opcode == OP_JAL);
  assign is_jalr  = (opcode == OP_JALR);
  assign link_rd  = (rd == 5'd1) || (rd == 5'd5);
  assign link_rs1 = (rs1 == 5'd1) || (rs1 == 5'd5);
  assign is_ret   = is_jalr && link_rs1 && !link_rd;
  assign is_swap  = is_jalr && link_rd && link_rs1 && (rs1 != rd);
  assign is_push  = (is_jal || is_jalr) && link_rd && !is_swap;

  // History is zero-extended to the index width before hashing.
  assign pred_idx_o = pc_i[IDX_BITS+1:2] ^ IDX_BITS'(ghr);
  assign pred_ghr_o = ghr;
  assign taken      = pht[pred_idx_o][1];

  always_comb begin
    br_pred_o     = 1'b0;
    new_pc_pred_o = pc_next;
    unique case (1'b1)
      is_cond: begin
        br_pred_o     = taken;
        new_pc_pred_o = taken ? pc_i + imm_b : pc_next;
      end
      is_jal: begin
        br_pred_o     = 1'b1;
        new_pc_pred_o = pc_i + imm_j;
      end
      is_ret && (count != '0): begin
        br_pred_o     = 1'b1;
        new_pc_pred_o = ras[top];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ghr <= '0;
    end else if (res_miss_i && res_valid_i) begin
      ghr <= {res_ghr_i[GH_SIZE-2:0], res_taken_i};
    end else if (res_miss_i) begin
      ghr <= res_ghr_i;
    end else if (fetch_valid_i && is_cond) begin
      ghr <= {ghr[GH_SIZE-2:0], taken};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < PHT_SIZE; i++) pht[i] <= 2'b10;
    end else if (res_valid_i) begin
      if (res_taken_i && pht[res_idx_i] != 2'b11)
        pht[res_idx_i] <= pht[res_idx_i] + 2'b01;
      else if (!res_taken_i && pht[res_idx_i] != 2'b00)
        pht[res_idx_i] <= pht[res_idx_i] - 2'b01;
    end
  end

  logic          ras_en;
  logic          do_push;
  logic          do_repl;
  logic          do_pop;
  logic [RP-1:0] top_inc;
  logic [RP-1:0] top_dec;

  // Speculative RAS ops are skipped in a redirect cycle; no repair is done.
  assign ras_en  = fetch_valid_i && !res_miss_i;
  assign do_push = ras_en && (is_push || (is_swap && count == '0));
  assign do_repl = ras_en && is_swap && (count != '0);
  assign do_pop  = ras_en && is_ret && (count != '0);
  assign top_inc = top + 1'b1;
  assign top_dec = top - 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      top   <= '0;
      count <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) ras[i] <= '0;
    end else if (do_push) begin
      top          <= top_inc;
      ras[top_inc] <= pc_next;
      if (count != RAS_FULL) count <= count + 1'b1;
    end else if (do_repl) begin
      ras[top] <= pc_next;
    end else if (do_pop) begin
      top   <= top_dec;
      count <= count - 1'b1;
    end
  end

endmodule

// File: tb/tb_gshare_predictor.sv
// Directed scoreboard bench: fetch vectors push expectations,
// a negedge monitor pops and compares the combinational prediction.
module tb_gshare_predictor;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_valid_i;
  logic [31:0] instruction_i;
  logic [31:0] pc_i;
  logic        br_pred_o;
  logic [31:0] new_pc_pred_o;
  logic [5:0]  pred_idx_o;
  logic [5:0]  pred_ghr_o;
  logic        res_valid_i;
  logic        res_taken_i;
  logic        res_miss_i;
  logic [5:0]  res_idx_i;
  logic [5:0]  res_ghr_i;

  gshare_predictor #(
    .IDX_BITS(6), .GH_SIZE(6), .RAS_DEPTH(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .fetch_valid_i(fetch_valid_i),
    .instruction_i(instruction_i),
    .pc_i(pc_i),
    .br_pred_o(br_pred_o),
    .new_pc_pred_o(new_pc_pred_o),
    .pred_idx_o(pred_idx_o),
    .pred_ghr_o(pred_ghr_o),
    .res_valid_i(res_valid_i),
    .res_taken_i(res_taken_i),
    .res_miss_i(res_miss_i),
    .res_idx_i(res_idx_i),
    .res_ghr_i(res_ghr_i)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] BEQ  = 32'h0200_0063;
  localparam logic [31:0] BEQM = 32'hFE00_0EE3;
  localparam logic [31:0] NB   = 32'h0200_2063;
  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] JAL1 = 32'h1000_00EF;
  localparam logic [31:0] RET  = 32'h0000_8067;
  localparam logic [31:0] SWAP = 32'h0000_82E7;

  typedef struct {
    int          id;
    logic        br;
    logic [31:0] npc;
    logic [5:0]  idx;
    logic [5:0]  ghr;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   vid    = 0;
  int   checks = 0;
  int   errors = 0;

  task automatic cmp(string nm, int id, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec%0d: got %h expected %h", nm, id, act, exp);
    end
  endtask

  task automatic cmp_out(exp_t e);
    cmp("br_pred", e.id, {31'b0, br_pred_o}, {31'b0, e.br});
    cmp("new_pc", e.id, new_pc_pred_o, e.npc);
    cmp("pred_idx", e.id, {26'b0, pred_idx_o}, {26'b0, e.idx});
    cmp("pred_ghr", e.id, {26'b0, pred_ghr_o}, {26'b0, e.ghr});
  endtask

  always @(negedge clk) begin
    if (fetch_valid_i) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard: output with no expectation at %0t", $time);
      end else begin
        mon_e = q.pop_front();
        cmp_out(mon_e);
      end
    end
  end

  task automatic cyc(
    input logic        fv,
    input logic [31:0] ins,
    input logic [31:0] pc,
    input logic        eb,
    input logic [31:0] enpc,
    input logic [5:0]  eidx,
    input logic [5:0]  eghr,
    input logic        rv = 1'b0,
    input logic        rt = 1'b0,
    input logic        rm = 1'b0,
    input logic [5:0]  ridx = 6'd0,
    input logic [5:0]  rghr = 6'd0
  );
    exp_t e;
    @(posedge clk);
    #1;
    fetch_valid_i = fv;
    instruction_i = ins;
    pc_i          = pc;
    res_valid_i   = rv;
    res_taken_i   = rt;
    res_miss_i    = rm;
    res_idx_i     = ridx;
    res_ghr_i     = rghr;
    if (fv) begin
      vid++;
      e = '{vid, eb, enpc, eidx, eghr};
      q.push_back(e);
    end
  endtask

  task automatic resolve(input logic rt, input logic [5:0] ridx);
    cyc(1'b0, NOP, 32'h0, 1'b0, 32'h0, 6'h0, 6'h0, 1'b1, rt, 1'b0, ridx);
  endtask

  initial begin
    exp_t e;
    reset         = 1'b1;
    fetch_valid_i = 1'b0;
    instruction_i = NOP;
    pc_i          = '0;
    res_valid_i   = 1'b0;
    res_taken_i   = 1'b0;
    res_miss_i    = 1'b0;
    res_idx_i     = '0;
    res_ghr_i     = '0;
    #12 reset = 1'b0;

    cyc(1, BEQ, 32'h100, 1, 32'h120, 6'h00, 6'h00);
    resolve(0, 6'd5);
    resolve(0, 6'd5);
    resolve(0, 6'd5);
    cyc(1, BEQ, 32'h10, 0, 32'h14, 6'h05, 6'h01);
    resolve(1, 6'd5);
    cyc(1, BEQ, 32'h1C, 0, 32'h20, 6'h05, 6'h02);
    resolve(1, 6'd5);
    cyc(1, BEQ, 32'h04, 1, 32'h24, 6'h05, 6'h04);
    cyc(1, BEQ, 32'h30, 1, 32'h50, 6'h05, 6'h09, 1, 0, 0, 6'd5);

    cyc(1, BEQ, 32'h100, 1, 32'h120, 6'h13, 6'h13);
    cyc(1, BEQ, 32'h100, 1, 32'h120, 6'h27, 6'h27, 1, 0, 1, 6'd9, 6'h2A);
    cyc(1, NOP, 32'h200, 0, 32'h204, 6'h14, 6'h14);
    cyc(1, NOP, 32'h0, 0, 32'h4, 6'h14, 6'h14, 0, 0, 1, 6'd0, 6'h33);

    cyc(1, JAL1, 32'h200, 1, 32'h300, 6'h33, 6'h33, 0, 0, 1, 6'd0, 6'h33);
    cyc(1, RET, 32'h400, 0, 32'h404, 6'h33, 6'h33);
    cyc(1, JAL1, 32'h200, 1, 32'h300, 6'h33, 6'h33);
    cyc(1, RET, 32'h400, 1, 32'h204, 6'h33, 6'h33);
    cyc(1, RET, 32'h400, 0, 32'h404, 6'h33, 6'h33);

    cyc(1, JAL1, 32'h10, 1, 32'h110, 6'h37, 6'h33);
    cyc(1, JAL1, 32'h20, 1, 32'h120, 6'h3B, 6'h33);
    cyc(1, JAL1, 32'h30, 1, 32'h130, 6'h3F, 6'h33);
    cyc(1, JAL1, 32'h40, 1, 32'h140, 6'h23, 6'h33);
    cyc(1, JAL1, 32'h50, 1, 32'h150, 6'h27, 6'h33);
    cyc(1, RET, 32'h400, 1, 32'h54, 6'h33, 6'h33);
    cyc(1, RET, 32'h400, 1, 32'h44, 6'h33, 6'h33);
    cyc(1, RET, 32'h400, 1, 32'h34, 6'h33, 6'h33);
    cyc(1, RET, 32'h400, 1, 32'h24, 6'h33, 6'h33);
    cyc(1, RET, 32'h400, 0, 32'h404, 6'h33, 6'h33);

    cyc(1, JAL1, 32'h10, 1, 32'h110, 6'h37, 6'h33);
    cyc(1, SWAP, 32'h600, 0, 32'h604, 6'h33, 6'h33);
    cyc(1, RET, 32'h400, 1, 32'h604, 6'h33, 6'h33);
    cyc(1, RET, 32'h400, 0, 32'h404, 6'h33, 6'h33);

    cyc(1, JAL1, 32'h10, 1, 32'h110, 6'h37, 6'h33);
    @(posedge clk);
    #1;
    fetch_valid_i = 1'b1;
    instruction_i = RET;
    pc_i          = 32'h400;
    res_valid_i   = 1'b0;
    res_miss_i    = 1'b0;
    #1;
    cmp("pre_reset_br", 0, {31'b0, br_pred_o}, 32'h1);
    cmp("pre_reset_pc", 0, new_pc_pred_o, 32'h14);
    #1 reset = 1'b1;
    vid++;
    e = '{vid, 1'b0, 32'h404, 6'h00, 6'h00};
    q.push_back(e);
    resolve(0, 6'd5);
    cyc(0, NOP, 32'h0, 0, 32'h0, 6'h0, 6'h0);
    #2 reset = 1'b0;

    cyc(1, BEQ, 32'h14, 1, 32'h34, 6'h05, 6'h00);
    cyc(1, NB, 32'h100, 0, 32'h104, 6'h01, 6'h01);
    cyc(1, BEQM, 32'h0, 1, 32'hFFFF_FFFC, 6'h01, 6'h01);
    cyc(1, NOP, 32'h0, 0, 32'h4, 6'h03, 6'h03);
    cyc(0, NOP, 32'h0, 0, 32'h0, 6'h0, 6'h0);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard: %0d expectations left, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gshare_predictor.md
Name: gshare_predictor

Overview:
- Parametrised successor to the fetch-stage two-level predictor.
- Conditional branches are predicted with a gshare index, `pc_i[IDX_BITS+1:2] XOR ghr`, into a 2-bit saturating-counter PHT.
- The global history register (GHR) is updated speculatively at fetch and restored from a checkpoint on mispredict.
- A return-address stack (RAS) predicts JALR returns, which the previous block could not predict.
- Sits in fetch. The execute stage returns the index, checkpoint and outcome of each resolved branch.

Parameters:
- IDX_BITS, 6, PHT index width; PHT_SIZE = 2**IDX_BITS.
- GH_SIZE, 6, GHR width; must be <= IDX_BITS (history is zero-extended before XOR).
- RAS_DEPTH, 4, RAS entries; power of 2, >= 2.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- fetch_valid_i  in  1  instruction_i/pc_i valid this cycle; gates all speculative state updates.
- instruction_i  in  32  fetched instruction.
- pc_i  in  32  PC of instruction_i.
- br_pred_o  out  1  predict redirect (taken).
- new_pc_pred_o  out  32  predicted next PC.
- pred_idx_o  out  IDX_BITS  PHT index used; carried down the pipeline.
- pred_ghr_o  out  GH_SIZE  GHR value before this instruction's speculative shift (checkpoint).
- res_valid_i  in  1  a conditional branch resolves this cycle.
- res_taken_i  in  1  actual outcome.
- res_miss_i  in  1  mispredicted (direction or target); may also be asserted for a JALR target miss with res_valid_i=0.
- res_idx_i  in  IDX_BITS  pred_idx_o captured at fetch.
- res_ghr_i  in  GH_SIZE  pred_ghr_o captured at fetch.

Behaviour:
- Decode (combinational):
  - BRANCH opcode with funct3 in {BEQ, BNE, BLT, BGE, BLTU, BGEU} is "cond"; other funct3 values are not branches.
  - JAL is "jal". JALR is "jalr".
  - link(r) means r == x1 or r == x5.
- Prediction (combinational, same cycle):
  - cond: br_pred_o = PHT[idx][1]; new_pc_pred_o = taken ? pc_i+imm_b : pc_i+4.
  - jal: br_pred_o = 1; new_pc_pred_o = pc_i+imm_j.
  - jalr with link(rs1) && !link(rd) (return), RAS non-empty: br_pred_o = 1; new_pc_pred_o = RAS top.
  - Any other jalr, or a return with RAS empty: br_pred_o = 0; new_pc_pred_o = pc_i+4.
  - Non-branch: br_pred_o = 0; new_pc_pred_o = pc_i+4.
  - pred_idx_o and pred_ghr_o are always driven, regardless of instruction type.
- Arithmetic: all 32-bit; additions wrap modulo 2^32.
- GHR (sequential):
  - fetch_valid_i && cond: ghr <= {ghr[GH_SIZE-2:0], predicted_taken}.
  - res_miss_i && res_valid_i: ghr <= {res_ghr_i[GH_SIZE-2:0], res_taken_i}.
  - res_miss_i && !res_valid_i: ghr <= res_ghr_i.
  - Recovery has priority over a same-cycle fetch shift; the fetch shift is dropped.
- PHT (sequential):
  - On res_valid_i, PHT[res_idx_i] increments if res_taken_i and decrements otherwise.
  - Saturates at 2'b11 and 2'b00.
  - A same-cycle read of the entry being written returns the old value; there is no bypass.
- RAS (sequential): circular buffer with top pointer and count (0..RAS_DEPTH).
  - Push: fetch_valid_i && (jal || jalr) && link(rd). Writes pc_i+4; count saturates at RAS_DEPTH; when full, the oldest entry is overwritten (wrap).
  - Pop: fetch_valid_i && return. Only when count > 0; pop with count 0 is a no-op.
  - Pop-then-push: jalr with link(rd) && link(rs1) && rs1 != rd. Top is replaced with pc_i+4; count unchanged (a push if count was 0).
  - The RAS is not repaired on res_miss_i (accepted limitation). When res_miss_i is asserted with fetch_valid_i, the fetch-side RAS op is suppressed.
- Reset (asynchronous, immediate):
  - ghr = 0; every PHT entry = 2'b10 (weakly taken); RAS count = 0, top = 0, entries = 0.
  - Outputs are combinational from reset state: cond predicts taken; returns predict not-taken.
  - Reset mid-operation discards all history and in-flight checkpoints; res_* inputs are ignored while reset is high.

Test Plan:
- Reset, then cond BEQ at pc 0x100 with imm_b = +0x20 -> br_pred_o=1, new_pc_pred_o=0x120, pred_idx_o=0x00 ^ (0x100>>2 & 0x3F)=0x00, pred_ghr_o=0; next-cycle ghr=0b000001.
- 3 × res_valid_i, res_taken_i=0, res_idx_i=5 -> PHT[5] goes 10→01→00→00 (saturates); a fetch hitting idx 5 predicts not-taken with new_pc_pred_o = pc+4.
- Fetch cond (ghr becomes 0b000001), then res_miss_i=1, res_valid_i=1, res_ghr_i=0b101010, res_taken_i=0 in the same cycle as another cond fetch -> ghr=0b010100 and the fetch shift is dropped.
- JAL x1 at 0x200, then JALR x0,0(x1) at 0x400 -> JAL predicts taken to target; return predicts new_pc_pred_o=0x204, br_pred_o=1; RAS count returns to 0.
- RAS_DEPTH=4: five link calls at pcs 0x10, 0x20, 0x30, 0x40, 0x50, then five returns -> targets 0x54, 0x44, 0x34, 0x24, then br_pred_o=0 with pc+4 (0x14 lost to overwrite).
- Assert reset asynchronously mid-sequence (between clock edges) -> ghr=0, PHT entries read 2'b10, return predicts not-taken immediately, without waiting for a clock edge.
